flog_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bfloat16 log2 core (the philo + i2f pipeline) among N_REQ requesters. The arbiter accepts one operand at a time through a per-requester valid/ready handshake, issues it to the core as a single-cycle start pulse, and waits for the core's done pulse. It then returns the registered result to the owning requester, tagged by a one-hot response strobe. A watchdog flags an error if the core does not answer within TIMEOUT cycles.

---
 rtl/flog_arbiter.sv | 176 +++++++++++++++++
 tb/tb_flog_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flog_arbiter.sv
// flog_arbiter: round-robin arbiter/sequencer sharing one bfloat16 log2 core
// among N_REQ requesters. One operation in flight at a time:
// IDLE (grant) -> ISSUE (start pulse) -> WAIT (core or watchdog) -> RESP.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid_i / req_data_i      per-requester operand, word i at [i*W +: W]
//   req_ready_o                   one-hot accept, only in IDLE
//   rsp_valid_o                   one-hot 1-cycle result strobe to owner
//   rsp_data_o / rsp_err_o        registered result and timeout flag
//   busy_o                        high whenever not IDLE
//   core_valid_o                  1-cycle start pulse to the core
//   core_sign_o/exp_o/fract_o     operand to the core, held from ISSUE on
//   core_valid_i                  core done pulse (only honoured in WAIT)
//   core_s_i/core_e_i/core_f_i    core result
module flog_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned FRACT_WIDTH = 7,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_REQ-1:0]                             req_valid_i,
  input  logic [N_REQ*(1+EXP_WIDTH+FRACT_WIDTH)-1:0]   req_data_i,
  output logic [N_REQ-1:0]                             req_ready_o,
  output logic [N_REQ-1:0]                             rsp_valid_o,
  output logic [EXP_WIDTH+FRACT_WIDTH:0]               rsp_data_o,
  output logic                                         rsp_err_o,
  output logic                                         busy_o,
  output logic                                         core_valid_o,
  output logic                                         core_sign_o,
  output logic [EXP_WIDTH-1:0]                         core_exp_o,
  output logic [FRACT_WIDTH-1:0]                       core_fract_o,
  input  logic                                         core_valid_i,
  input  logic                                         core_s_i,
  input  logic [EXP_WIDTH-1:0]                         core_e_i,
  input  logic [FRACT_WIDTH-1:0]                       core_f_i
);

  localparam int unsigned W     = 1 + EXP_WIDTH + FRACT_WIDTH;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     operand;
  logic [W-1:0]     result;
  logic             err;

  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic             timeout_c;
  logic [W-1:0]     req_word [N_REQ];

  // Unpack the flat operand bus into one word per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data_i[i*W +: W];
  end

  // Rotating priority scan starting at ptr; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req_valid_i[PTR_W'((32'(ptr) + k) % N_REQ)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((32'(ptr) + k) % N_REQ);
      end
    end
  end

  assign ptr_inc   = PTR_W'((32'(grant_idx) + 1) % N_REQ);
  assign timeout_c = (cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs. req_ready_o is forced low while
  // rst is high so every output reads zero during reset.
  always_comb begin
    state_nxt    = state;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    core_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (grant_vld) begin
          state_nxt = S_ISSUE;
          if (!rst) begin
            req_ready_o = N_REQ'(1) << grant_idx;
          end
        end
      end
      S_ISSUE: begin
        core_valid_o = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid_i || timeout_c) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o = N_REQ'(1) << owner;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: grant bookkeeping, watchdog counter, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      operand <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            operand <= req_word[grant_idx];
            owner   <= grant_idx;
            ptr     <= ptr_inc;
          end
        end
        S_ISSUE: begin
          cnt <= '0;
        end
        S_WAIT: begin
          // A core answer in the timeout cycle still counts as success.
          if (core_valid_i) begin
            result <= {core_s_i, core_e_i, core_f_i};
            err    <= 1'b0;
          end else if (timeout_c) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign core_sign_o  = operand[W-1];
  assign core_exp_o   = operand[W-2 -: EXP_WIDTH];
  assign core_fract_o = operand[FRACT_WIDTH-1:0];
  assign rsp_data_o   = result;
  assign rsp_err_o    = err;

endmodule

// File: tb/tb_flog_arbiter.sv
// Directed self-checking bench for flog_arbiter (N_REQ=4, TIMEOUT=8).
module tb_flog_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] rd [4];
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        core_valid;
  logic        core_sign;
  logic [7:0]  core_exp;
  logic [6:0]  core_fract;
  logic        core_done = 1'b0;
  logic [15:0] core_res = '0;
  logic [15:0] core_op;
  logic [42:0] all_out;
  int          checks = 0;
  int          failures = 0;

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};
  assign core_op  = {core_sign, core_exp, core_fract};
  assign all_out  = {req_ready, rsp_valid, rsp_data, rsp_err, busy, core_valid, core_op};

  flog_arbiter #(
    .N_REQ(4), .EXP_WIDTH(8), .FRACT_WIDTH(7), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .busy_o(busy), .core_valid_o(core_valid),
    .core_sign_o(core_sign), .core_exp_o(core_exp), .core_fract_o(core_fract),
    .core_valid_i(core_done), .core_s_i(core_res[15]),
    .core_e_i(core_res[14:7]), .core_f_i(core_res[6:0])
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) rd[i] = 16'h0000;
    req_valid = 4'b1111;
    step();
    step();
    checks++;
    if (all_out !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    rd[0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    checks++;
    if ({busy, req_ready} !== 5'b0_0001) begin
      failures++;
      $display("FAIL single_grant got=%b exp=00001", {busy, req_ready});
    end
    step(); // ISSUE
    checks++;
    if ({core_valid, busy, req_ready} !== 6'b11_0000) begin
      failures++;
      $display("FAIL single_issue got=%b exp=110000", {core_valid, busy, req_ready});
    end
    checks++;
    if (core_op !== 16'h4000) begin
      failures++;
      $display("FAIL single_operand got=%h exp=4000", core_op);
    end
    req_valid = 4'b0000;
    step(); // WAIT cycle 1
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({core_valid, rsp_valid} !== 5'b0_0000) begin
        failures++;
        $display("FAIL single_wait%0d got=%b exp=00000", k, {core_valid, rsp_valid});
      end
      step();
    end
    core_res = 16'h3F80;
    core_done = 1'b1; // fifth cycle after ISSUE
    step();
    core_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, busy} !== {4'b0001, 1'b0, 16'h3F80, 1'b1}) begin
      failures++;
      $display("FAIL single_resp got=%b_%b_%h_%b exp=0001_0_3f80_1", rsp_valid, rsp_err, rsp_data, busy);
    end
    step();
    checks++;
    if ({rsp_valid, busy, rsp_data} !== {4'b0000, 1'b0, 16'h3F80}) begin
      failures++;
      $display("FAIL single_idle got=%b_%b_%h exp=0000_0_3f80", rsp_valid, busy, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = 16'h4000 + 16'(i);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      #1;
      checks++;
      if (req_ready !== 4'(1 << g)) begin
        failures++;
        $display("FAIL rr_ready%0d got=%b exp=%b", n, req_ready, 4'(1 << g));
      end
      step(); // ISSUE
      checks++;
      if ({core_valid, req_ready, core_op} !== {1'b1, 4'b0000, 16'h4000 + 16'(g)}) begin
        failures++;
        $display("FAIL rr_issue%0d got=%b_%b_%h exp=1_0000_%h", n, core_valid, req_ready, core_op, 16'h4000 + 16'(g));
      end
      step(); // WAIT
      core_res = 16'h3F00 + 16'(g);
      core_done = 1'b1;
      step(); // RESP
      core_done = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {4'(1 << g), 1'b0, 16'h3F00 + 16'(g)}) begin
        failures++;
        $display("FAIL rr_resp%0d got=%b_%b_%h exp=%b_0_%h", n, rsp_valid, rsp_err, rsp_data, 4'(1 << g), 16'h3F00 + 16'(g));
      end
      step(); // IDLE
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_timeout();
    rd[3] = 16'h1234;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL to_grant got=%b exp=1000", req_ready);
    end
    step(); // ISSUE
    req_valid = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({rsp_valid, busy} !== 5'b0000_1) begin
        failures++;
        $display("FAIL to_wait%0d got=%b exp=00001", k, {rsp_valid, busy});
      end
    end
    step(); // ISSUE + 9
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b1000, 1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL to_resp got=%b_%b_%h exp=1000_1_0000", rsp_valid, rsp_err, rsp_data);
    end
    step();
    rd[0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL to_next_grant got=%b exp=0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
    core_res = 16'h3F80;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b0001, 1'b0, 16'h3F80}) begin
      failures++;
      $display("FAIL to_next_resp got=%b_%b_%h exp=0001_0_3f80", rsp_valid, rsp_err, rsp_data);
    end
    step();
  endtask

  task automatic test_boundary();
    rd[1] = 16'h4100;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bd_grant got=%b exp=0010", req_ready);
    end
    step(); // ISSUE
    req_valid = 4'b0000;
    for (int k = 0; k < 8; k++) step();
    core_res = 16'h5555; // counter at TIMEOUT-1 this cycle
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b0010, 1'b0, 16'h5555}) begin
      failures++;
      $display("FAIL bd_resp got=%b_%b_%h exp=0010_0_5555", rsp_valid, rsp_err, rsp_data);
    end
    step(); // IDLE
    core_res = 16'hAAAA;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy, core_valid, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b0, 4'b0000, 1'b0, 16'h5555}) begin
        failures++;
        $display("FAIL bd_idle_done%0d got=%b_%b_%b_%b_%h exp=0_0_0000_0_5555", k, busy, core_valid, rsp_valid, rsp_err, rsp_data);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) rd[i] = 16'h4000 + 16'(i);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rw_grant got=%b exp=0100", req_ready);
    end
    step(); // ISSUE
    step(); // WAIT
    step(); // WAIT
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 43'd0) begin
      failures++;
      $display("FAIL rw_async_reset got=%h exp=0", all_out);
    end
    req_valid = 4'b0000;
    step();
    rst = 1'b0;
    core_res = 16'h7777;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rsp_valid, busy, rsp_data} !== {4'b0000, 1'b0, 16'h0000}) begin
        failures++;
        $display("FAIL rw_late_done%0d got=%b_%b_%h exp=0000_0_0000", k, rsp_valid, busy, rsp_data);
      end
      step();
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rw_ptr_restart got=%b exp=0001", req_ready);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    rd[1] = 16'h3000;
    req_valid = 4'b0010;
    #1;
    checks++;
    if ({busy, req_ready} !== 5'b0_0010) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=00010", {busy, req_ready});
    end
    step(); // ISSUE
    rd[2] = 16'h2000;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({busy, req_ready, rsp_valid} !== 9'b1_0000_0000) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b exp=100000000", k, {busy, req_ready, rsp_valid});
      end
      if (k == 2) begin
        core_res = 16'h1111;
        core_done = 1'b1;
      end
      step();
    end
    core_done = 1'b0;
    checks++;
    if ({busy, req_ready, rsp_valid, rsp_data} !== {1'b1, 4'b0000, 4'b0010, 16'h1111}) begin
      failures++;
      $display("FAIL bp_resp1 got=%b_%b_%b_%h exp=1_0000_0010_1111", busy, req_ready, rsp_valid, rsp_data);
    end
    step(); // IDLE
    checks++;
    if ({busy, req_ready} !== 5'b0_0100) begin
      failures++;
      $display("FAIL bp_grant2 got=%b exp=00100", {busy, req_ready});
    end
    step(); // ISSUE
    req_valid = 4'b0000;
    checks++;
    if ({busy, core_valid, core_op} !== {1'b1, 1'b1, 16'h2000}) begin
      failures++;
      $display("FAIL bp_issue2 got=%b_%b_%h exp=1_1_2000", busy, core_valid, core_op);
    end
    step();
    core_res = 16'h2222;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b0100, 1'b0, 16'h2222}) begin
      failures++;
      $display("FAIL bp_resp2 got=%b_%b_%h exp=0100_0_2222", rsp_valid, rsp_err, rsp_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_boundary();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
